// File: rtl/spie_burst_ctrl_if.sv
// rtl/spie_burst_ctrl_if.sv - link between spie_burst_ctrl and the spie_rxtx shift engine
interface spie_burst_ctrl_if;
  logic        cs_n;
  logic        spi_start;
  logic [31:0] spi_data_tx;
  logic        spi_rdy;
  logic [31:0] spi_data_rx;

  modport master (output cs_n, spi_start, spi_data_tx, input spi_rdy, spi_data_rx);
  modport slave  (input cs_n, spi_start, spi_data_tx, output spi_rdy, spi_data_rx);
endinterface

// File: rtl/spie_burst_ctrl.sv
// rtl/spie_burst_ctrl.sv - burst sequencer feeding spie_rxtx from TX/RX word FIFOs
// Owns chip select timing; one word in flight, RX full stalls the next launch.
module spie_burst_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [31:0]            push_data,
  input  logic                   pop,
  output logic [31:0]            head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // a full FIFO still takes a word when its head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module spie_burst_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [31:0]               wr_data,
  input  logic                      rd_en,
  output logic [31:0]               rd_data,
  input  logic                      cs_req,
  input  logic                      rx_discard,
  output logic                      tx_full,
  output logic                      rx_empty,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      busy,
  spie_burst_ctrl_if.master         spi
);
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, ARM, WAIT, HOLD} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [31:0]      tx_head;
  logic             tx_empty;
  logic             rx_full;
  logic             launch;
  logic             tx_pop;
  logic             rx_push;
  logic             start_next;
  logic             cs_n_next;
  logic [31:0]      data_tx_next;

  spie_burst_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(wr_en), .push_data(wr_data), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  spie_burst_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .push_data(spi.spi_data_rx), .pop(rd_en),
    .head(rd_data), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // launching only with RX room is what keeps the RX FIFO from overflowing
  assign launch = (state == ACTIVE) && cs_req && !tx_empty && (rx_discard || !rx_full);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      spi.cs_n        <= 1'b1;
      spi.spi_start   <= 1'b0;
      spi.spi_data_tx <= '0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      spi.cs_n        <= cs_n_next;
      spi.spi_start   <= start_next;
      spi.spi_data_tx <= data_tx_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (cs_req) begin
          state_next = SETUP;
          cnt_next   = CNT_W'(CS_SETUP - 1);
        end
      end
      SETUP: begin
        if (!cs_req) begin
          state_next = HOLD;
          cnt_next   = CNT_W'(CS_HOLD - 1);
        end else if (cnt == '0) begin
          state_next = ACTIVE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (!cs_req) begin
          state_next = HOLD;
          cnt_next   = CNT_W'(CS_HOLD - 1);
        end else if (launch) begin
          state_next = ARM;
        end
      end
      // rdy is still high from the previous word here, so it is not looked at
      ARM:  state_next = WAIT;
      WAIT: if (spi.spi_rdy) state_next = ACTIVE;
      HOLD: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_pop       = launch;
    rx_push      = (state == WAIT) && spi.spi_rdy && !rx_discard;
    start_next   = launch;
    data_tx_next = launch ? tx_head : spi.spi_data_tx;
    cs_n_next    = (state_next == IDLE);
  end
endmodule

// File: tb/tb_spie_burst_ctrl.sv
// tb/tb_spie_burst_ctrl.sv - scoreboard bench for spie_burst_ctrl with a behavioural spie_rxtx
module tb_spie_burst_ctrl;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        cs_req = 1'b0;
  logic        rx_discard = 1'b0;
  logic        tx_full, rx_empty, busy;
  logic [3:0]  tx_count, rx_count;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_starts = 0;
  int          done_cnt = 0;
  int          lat = 0;
  logic [31:0] cur_word = '0;
  logic [31:0] tx_exp[$];
  logic [31:0] rx_exp[$];

  spie_burst_ctrl_if spi_if ();

  spie_burst_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .CS_SETUP(2), .CS_HOLD(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .cs_req(cs_req), .rx_discard(rx_discard), .tx_full(tx_full), .rx_empty(rx_empty),
    .tx_count(tx_count), .rx_count(rx_count), .busy(busy), .spi(spi_if.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lb(input logic [31:0] x);
    return x ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // spie_rxtx stand-in: rdy drops after start, returns LAT cycles later with the looped-back word
  always @(negedge clk) begin
    if (rst) begin
      spi_if.spi_rdy     = 1'b1;
      spi_if.spi_data_rx = '0;
      lat = 0;
    end else if (spi_if.spi_start) begin
      n_starts++;
      if (tx_exp.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        cur_word = tx_exp.pop_front();
        check("spi_data_tx", spi_if.spi_data_tx, cur_word);
      end
      spi_if.spi_rdy = 1'b0;
      lat = LAT;
    end else if (lat != 0) begin
      lat--;
      if (lat == 0) begin
        spi_if.spi_rdy     = 1'b1;
        spi_if.spi_data_rx = lb(spi_if.spi_data_tx);
        done_cnt++;
        if (!rx_discard) rx_exp.push_back(lb(cur_word));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; cs_req = 1'b0; rx_discard = 1'b0;
    tick(2);
    tx_exp.delete(); rx_exp.delete();
    n_starts = 0; done_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    if (tx_exp.size() < TXD) tx_exp.push_back(d);
    wr_en = 1'b1; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic pop_word();
    if (rx_exp.size() == 0) check("rx_underflow", 32'd1, 32'd0);
    else check("rd_data", rd_data, rx_exp.pop_front());
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    for (int i = 0; i < 400 && n_starts < n; i++) tick(1);
    check("timeout_starts", 32'(n_starts >= n), 32'd1);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 400 && done_cnt < n; i++) tick(1);
    check("timeout_done", 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 400 && int'(rx_count) != n; i++) tick(1);
    check("timeout_rx_count", 32'(rx_count), 32'(n));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) tick(1);
    check("timeout_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: observed no end of test, required end within 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset values, setup latency, 3-word burst, hold timing
    do_reset();
    check("rst_cs_n", 32'(spi_if.cs_n), 32'd1);
    check("rst_start", 32'(spi_if.spi_start), 32'd0);
    check("rst_data_tx", spi_if.spi_data_tx, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    check("rst_rx_count", 32'(rx_count), 32'd0);
    push_word(32'h11); push_word(32'h22); push_word(32'h33);
    check("t1_tx_count", 32'(tx_count), 32'd3);
    cs_req = 1'b1;
    tick(1);
    check("t1_cs_n_edge1", 32'(spi_if.cs_n), 32'd0);
    check("t1_busy_edge1", 32'(busy), 32'd1);
    tick(1);
    check("t1_start_edge2", 32'(spi_if.spi_start), 32'd0);
    tick(1);
    check("t1_start_edge3", 32'(spi_if.spi_start), 32'd0);
    tick(1);
    check("t1_start_edge4", 32'(spi_if.spi_start), 32'd1);
    wait_rx(3);
    check("t1_starts", 32'(n_starts), 32'd3);
    cs_req = 1'b0;
    tick(1);
    check("t1_busy_hold1", 32'(busy), 32'd1);
    tick(1);
    check("t1_busy_hold2", 32'(busy), 32'd1);
    check("t1_cs_n_hold2", 32'(spi_if.cs_n), 32'd0);
    tick(1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_cs_n_end", 32'(spi_if.cs_n), 32'd1);
    for (int i = 0; i < 3; i++) pop_word();
    check("t1_rx_empty", 32'(rx_empty), 32'd1);

    // 2: overfill TX with cs_req low
    do_reset();
    for (int i = 0; i < 9; i++) push_word(32'h200 + 32'(i));
    check("t2_tx_full", 32'(tx_full), 32'd1);
    check("t2_tx_count", 32'(tx_count), 32'd8);
    tick(5);
    check("t2_no_start", 32'(n_starts), 32'd0);

    // 3: RX stall, drain, then discard mode
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h300 + 32'(i));
    cs_req = 1'b1;
    wait_starts(2);
    push_word(32'h308); push_word(32'h309);
    wait_rx(8);
    tick(20);
    check("t3_stall_starts", 32'(n_starts), 32'd8);
    check("t3_stall_busy", 32'(busy), 32'd1);
    check("t3_stall_cs_n", 32'(spi_if.cs_n), 32'd0);
    check("t3_stall_tx_count", 32'(tx_count), 32'd2);
    pop_word(); pop_word();
    wait_starts(10);
    wait_done(10);
    tick(2);
    check("t3_refill_rx_count", 32'(rx_count), 32'd8);
    check("t3_refill_tx_count", 32'(tx_count), 32'd0);
    rx_discard = 1'b1;
    push_word(32'h30A); push_word(32'h30B);
    wait_done(12);
    tick(2);
    check("t3_discard_starts", 32'(n_starts), 32'd12);
    check("t3_discard_rx_count", 32'(rx_count), 32'd8);
    rx_discard = 1'b0;
    for (int i = 0; i < 8; i++) pop_word();
    cs_req = 1'b0;
    wait_idle();

    // 4: cs_req drop while word 2 is in flight
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'h400 + 32'(i));
    cs_req = 1'b1;
    wait_starts(2);
    cs_req = 1'b0;
    wait_done(2);
    tick(2);
    check("t4_cs_n_hold", 32'(spi_if.cs_n), 32'd0);
    tick(1);
    check("t4_cs_n_release", 32'(spi_if.cs_n), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_tx_count", 32'(tx_count), 32'd2);
    check("t4_rx_count", 32'(rx_count), 32'd2);
    check("t4_starts", 32'(n_starts), 32'd2);
    pop_word(); pop_word();

    // 5: reset while waiting for rdy
    do_reset();
    push_word(32'h501); push_word(32'h502);
    cs_req = 1'b1;
    wait_starts(1);
    rst = 1'b1;
    tick(1);
    check("t5_cs_n", 32'(spi_if.cs_n), 32'd1);
    check("t5_start", 32'(spi_if.spi_start), 32'd0);
    check("t5_tx_count", 32'(tx_count), 32'd0);
    check("t5_rx_count", 32'(rx_count), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    do_reset();

    // 6: push+pop on full TX, push+pop on RX at RXD-1, order across wrap
    for (int i = 0; i < 8; i++) push_word(32'h600 + 32'(i));
    check("t6_tx_full", 32'(tx_full), 32'd1);
    cs_req = 1'b1;
    tick(3);
    wr_en = 1'b1; wr_data = 32'h6A6;
    tx_exp.push_back(32'h6A6);
    tick(1);
    wr_en = 1'b0;
    check("t6_tx_count_pushpop", 32'(tx_count), 32'd8);
    check("t6_start", 32'(spi_if.spi_start), 32'd1);
    wait_rx(RXD - 1);
    for (int i = 0; i < 200 && done_cnt < 8; i++) begin
      @(negedge clk);
      #1;
    end
    check("timeout_t6_word8", 32'(done_cnt), 32'd8);
    check("rd_data", rd_data, rx_exp.pop_front());
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("t6_rx_count_pushpop", 32'(rx_count), 32'(RXD - 1));
    wait_done(9);
    tick(2);
    check("t6_rx_count_final", 32'(rx_count), 32'd8);
    check("t6_tx_count_final", 32'(tx_count), 32'd0);
    for (int i = 0; i < 8; i++) pop_word();
    cs_req = 1'b0;
    wait_idle();
    check("t6_rx_empty", 32'(rx_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
